// File: rtl/mux_nch_seq_pkg.sv
// rtl/mux_nch_seq_pkg.sv - shared state and mode encodings for the N-channel sequencing mux
// Contents:
//   ST_IDLE / ST_MANUAL / ST_SCAN : state register encodings
//   MODE_MANUAL / MODE_SCAN       : mode_in encodings
package mux_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MANUAL = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nch_seq_if.sv
// rtl/mux_nch_seq_if.sv - source/consumer bundle of the N-channel sequencing mux
// Signals:
//   data_in   : CHANNELS*WIDTH packed channel data, channel k at [k*WIDTH +: WIDTH]
//   sel_in    : manual channel select
//   mode_in   : 0 = manual, 1 = scan
//   en_in     : enable
//   y_out     : registered selected data
//   ch_out    : channel y_out came from
//   valid_out : y_out/ch_out updated this cycle
//   wrap_out  : scan wrapped from the last channel to channel 0
//   err_out   : manual select was out of range
// Modports: master drives the inputs, slave is the mux itself.
interface mux_nch_seq_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel_in;
    logic                      mode_in;
    logic                      en_in;
    logic [WIDTH-1:0]          y_out;
    logic [SEL_W-1:0]          ch_out;
    logic                      valid_out;
    logic                      wrap_out;
    logic                      err_out;

    modport master (
        output data_in, sel_in, mode_in, en_in,
        input  y_out, ch_out, valid_out, wrap_out, err_out
    );

    modport slave (
        input  data_in, sel_in, mode_in, en_in,
        output y_out, ch_out, valid_out, wrap_out, err_out
    );
endinterface

// File: rtl/mux_nch_seq_dwell_counter.sv
// rtl/mux_nch_seq_dwell_counter.sv - dwell timer that ticks on every DWELL-th enabled cycle
// Ports:
//   clk_in   : clock
//   rst_n_in : asynchronous active-low reset
//   clr_in   : synchronous clear (dominates en_in)
//   en_in    : count enable
//   tick_out : high on the enabled cycle where the count sits at DWELL-1
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clr_in,
    input  logic en_in,
    output logic tick_out
);
    localparam int              CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    // Combinational so the caller can advance on the same edge the count wraps.
    assign tick_out = en_in && !clr_in && (cnt == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (clr_in) begin
            cnt <= '0;
        end else if (en_in) begin
            cnt <= tick_out ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mux_nch_seq.sv
// rtl/mux_nch_seq.sv - registered N-channel mux with manual select and round-robin scan
// Ports:
//   clk_in   : clock, all logic rising-edge
//   rst_n_in : asynchronous active-low reset
//   bus      : mux_nch_seq_if.slave (data/select/mode/enable in, data/tag/flags out)
module mux_nch_seq
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    mux_nch_seq_if.slave bus
);
    localparam int               SEL_W   = $clog2(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [SEL_W-1:0] ch_q;
    logic [SEL_W-1:0] ch_nxt;
    logic [WIDTH-1:0] y_q;
    logic             wrap_q;
    logic             err_q;
    logic             sel_ok;
    logic             scan_en;
    logic             tick;

    always_comb begin
        state_nxt = ST_IDLE;
        if (bus.en_in) begin
            state_nxt = (bus.mode_in == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
    end

    // Counter only runs while scanning; any other cycle parks it at 0 so a
    // fresh scan always dwells the full DWELL edges on its starting channel.
    assign scan_en = (state_nxt == ST_SCAN);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr_in   (!scan_en),
        .en_in    (scan_en),
        .tick_out (tick)
    );

    // Widen before comparing so non-power-of-two channel counts are handled.
    assign sel_ok = (32'(bus.sel_in) < CHANNELS);

    always_comb begin
        ch_nxt = ch_q;
        case (state_nxt)
            ST_MANUAL: if (sel_ok) ch_nxt = bus.sel_in;
            ST_SCAN:   if (tick)   ch_nxt = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
            default:   ch_nxt = ch_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= ST_IDLE;
            ch_q   <= '0;
            y_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_nxt != ST_IDLE) begin
                // y_out always reloads so held channels still show live data.
                ch_q   <= ch_nxt;
                y_q    <= bus.data_in[32'(ch_nxt)*WIDTH +: WIDTH];
                wrap_q <= scan_en && tick && (ch_q == LAST_CH);
                err_q  <= (state_nxt == ST_MANUAL) && !sel_ok;
            end
        end
    end

    assign bus.y_out     = y_q;
    assign bus.ch_out    = ch_q;
    assign bus.valid_out = (state != ST_IDLE);
    assign bus.wrap_out  = wrap_q;
    assign bus.err_out   = err_q;
endmodule

// File: tb/tb_mux_nch_seq.sv
// tb/tb_mux_nch_seq.sv - self-checking bench for mux_nch_seq (4ch/dwell 2 and 3ch/dwell 1)
module tb_mux_nch_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_nch_seq_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
    mux_nch_seq_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

    mux_nch_seq #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_a)
    );

    mux_nch_seq #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus per instance (0 = a, 1 = b)
    logic [31:0] data [2];
    int sel [2];
    int mode [2];
    int en [2];

    // Reference model: scan position is derived from the number of scan
    // edges since entering scan, not from a dwell counter.
    int NCH [2] = '{4, 3};
    int NDW [2] = '{2, 1};
    int m_ch [2], m_y [2], m_valid [2], m_wrap [2], m_err [2];
    int m_scan [2], m_start [2], m_age [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ch[i] = 0; m_y[i] = 0; m_valid[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
            m_scan[i] = 0; m_start[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        m_wrap[i] = 0;
        m_err[i]  = 0;
        if (en[i] == 0) begin
            m_valid[i] = 0;
            m_scan[i]  = 0;
        end else begin
            m_valid[i] = 1;
            if (mode[i] == 0) begin
                m_scan[i] = 0;
                if (sel[i] < NCH[i]) m_ch[i] = sel[i];
                else m_err[i] = 1;
            end else begin
                if (m_scan[i] == 0) begin
                    m_scan[i] = 1; m_start[i] = m_ch[i]; m_age[i] = 0;
                end else begin
                    m_age[i]++;
                end
                m_ch[i] = (m_start[i] + (m_age[i] + 1) / NDW[i]) % NCH[i];
                m_wrap[i] = (((m_age[i] + 1) % NDW[i]) == 0 && m_ch[i] == 0) ? 1 : 0;
            end
            m_y[i] = int'((data[i] >> (8 * m_ch[i])) & 32'hFF);
        end
    endtask

    task automatic drive();
        logic [31:0] sa, sb;
        sa = sel[0]; sb = sel[1];
        bus_a.data_in = data[0];
        bus_a.sel_in  = sa[1:0];
        bus_a.mode_in = mode[0][0];
        bus_a.en_in   = en[0][0];
        bus_b.data_in = data[1][23:0];
        bus_b.sel_in  = sb[1:0];
        bus_b.mode_in = mode[1][0];
        bus_b.en_in   = en[1][0];
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/a.y"},     32'(bus_a.y_out),     m_y[0]);
        chk({tag, "/a.ch"},    32'(bus_a.ch_out),    m_ch[0]);
        chk({tag, "/a.valid"}, 32'(bus_a.valid_out), m_valid[0]);
        chk({tag, "/a.wrap"},  32'(bus_a.wrap_out),  m_wrap[0]);
        chk({tag, "/a.err"},   32'(bus_a.err_out),   m_err[0]);
        chk({tag, "/b.y"},     32'(bus_b.y_out),     m_y[1]);
        chk({tag, "/b.ch"},    32'(bus_b.ch_out),    m_ch[1]);
        chk({tag, "/b.valid"}, 32'(bus_b.valid_out), m_valid[1]);
        chk({tag, "/b.wrap"},  32'(bus_b.wrap_out),  m_wrap[1]);
        chk({tag, "/b.err"},   32'(bus_b.err_out),   m_err[1]);
    endtask

    task automatic step(input string tag);
        drive();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all(tag);
    endtask

    initial begin
        int exp_seq [8];
        int wraps;
        int found;
        int held;
        exp_seq = '{0, 1, 1, 2, 2, 3, 3, 0};

        // Reset held with the block enabled: outputs must stay cleared
        rst_n = 1'b0;
        data[0] = 32'hD4C3B2A1; data[1] = 32'h00C3B2A1;
        sel = '{0, 0}; mode = '{1, 1}; en = '{1, 1};
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Release with enable low: valid stays low
        @(negedge clk);
        rst_n = 1'b1;
        en = '{0, 0};
        step("rel_idle");
        step("rel_idle");

        // Manual select on every legal channel; b scans with DWELL=1
        en = '{1, 1}; mode = '{0, 1};
        for (int k = 0; k < 4; k++) begin
            sel[0] = k;
            step("manual");
            chk("manual_y", 32'(bus_a.y_out), (32'hD4C3B2A1 >> (8 * k)) & 32'hFF);
        end

        // Scan with DWELL=2 from channel 0
        sel[0] = 0;
        step("pre_scan");
        mode[0] = 1;
        wraps = 0;
        for (int k = 0; k < 8; k++) begin
            step("scan");
            chk("scan_seq", 32'(bus_a.ch_out), exp_seq[k]);
            wraps += int'(bus_a.wrap_out);
        end
        chk("scan_wraps", wraps, 1);

        // Mode switch at channel 2
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step("to_ch2");
            if (bus_a.ch_out == 2'd2) found = 1;
        end
        chk("reach_ch2", found, 1);
        mode[0] = 0; sel[0] = 0;
        step("sw_manual");
        chk("sw_manual_ch", 32'(bus_a.ch_out), 0);
        mode[0] = 1;
        step("sw_scan");
        chk("sw_scan_hold", 32'(bus_a.ch_out), 0);
        step("sw_scan");
        chk("sw_scan_adv", 32'(bus_a.ch_out), 1);

        // Enable gating mid-scan
        step("gate_pre");
        held = int'(bus_a.ch_out);
        en = '{0, 0};
        for (int k = 0; k < 3; k++) begin
            step("gated");
            chk("gated_ch", 32'(bus_a.ch_out), held);
        end
        en = '{1, 1};
        for (int k = 0; k < 4; k++) step("regate");

        // Illegal select on the 3-channel instance
        mode[1] = 0; data[1] = 32'h00C3B2A1;
        sel[1] = 1; step("illegal");
        sel[1] = 3; step("illegal");
        chk("illegal_err", 32'(bus_b.err_out), 1);
        chk("illegal_ch", 32'(bus_b.ch_out), 1);
        sel[1] = 1; step("illegal");
        chk("illegal_clr", 32'(bus_b.err_out), 0);

        // Reset asserted mid-scan, then restart from channel 0
        mode = '{1, 1};
        step("pre_rst");
        step("pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step("post_rst");

        // Randomised traffic with sticky modes so scans run for a while
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++) begin
                data[i] = $urandom;
                sel[i] = $urandom_range(0, 3);
                if ($urandom_range(0, 7) == 0) mode[i] = 1 - mode[i];
                en[i] = ($urandom_range(0, 9) == 0) ? 0 : 1;
            end
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_nch_seq.md
# mux_nch_seq

Parametrised, registered N-channel multiplexer with a manual-select mode and an automatic round-robin scan mode with a programmable dwell time. It generalises the combinational 4:1 mux to CHANNELS inputs of WIDTH bits each and adds an output register, a valid flag, a channel tag, a wrap pulse and an illegal-select flag. It sits between a bank of sampled data sources and a single downstream consumer, such as a logger or serialiser.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2, need not be a power of 2)
- DWELL, 4, cycles spent on each channel in scan mode (≥1)
- SEL_W, $clog2(CHANNELS), select/channel-tag width (derived; not overridden)

- clk_in  input  1  single clock; all logic is rising-edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- data_in  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel_in  input  SEL_W  manual channel select.
- mode_in  input  1  0 = manual, 1 = scan.
- en_in  input  1  enable; when low the block idles.
- y_out  output  WIDTH  registered selected data.
- ch_out  output  SEL_W  channel that y_out was taken from.
- valid_out  output  1  y_out/ch_out were updated this cycle.
- wrap_out  output  1  one-cycle pulse when the scan moves from channel CHANNELS-1 to channel 0.
- err_out  output  1  one-cycle pulse when sel_in ≥ CHANNELS in manual mode.

## Operation
- **FSM states:** IDLE, MANUAL, SCAN. The state register reflects the mode used at the last edge.
- **Transitions** (evaluated every edge):
  - en_in=0 → IDLE.
  - en_in=1 and mode_in=0 → MANUAL.
  - en_in=1 and mode_in=1 → SCAN.
- **IDLE:**
  - y_out and ch_out hold.
  - valid_out, wrap_out and err_out are 0.
  - Dwell counter is cleared.
- **MANUAL:**
  - Next channel = sel_in if sel_in < CHANNELS.
  - Otherwise the next channel = current ch_out, y_out reloads from that channel, and err_out=1.
  - valid_out=1 every cycle.
  - Dwell counter is held at 0.
- **SCAN:**
  - Dwell counter counts 0..DWELL-1.
  - While the count < DWELL-1: the channel holds and the count increments.
  - At DWELL-1: the count returns to 0 and the channel advances by 1. From CHANNELS-1 it wraps to 0, with wrap_out=1 on the same edge.
  - y_out reloads from the current channel every cycle, so data stays live during the dwell.
  - valid_out=1 every cycle.
- **Entering SCAN** from IDLE or MANUAL: the scan starts at the current ch_out with the dwell counter at 0. The first advance happens DWELL cycles later.
- **SCAN → MANUAL:** sel_in is used on the first MANUAL edge and the dwell counter clears. A wrap in progress is abandoned.
- **DWELL=1:** the channel advances every cycle.
- **Width rules:**
  - Dwell counter width = max(1, $clog2(DWELL)).
  - Channel arithmetic is modulo CHANNELS, not 2^SEL_W.
  - Scan never visits an illegal index.

## Timing
- **Latency:** 1 cycle. Values sampled at edge N appear on the outputs after edge N, with y_out = data_in[ch_next] and ch_out = ch_next, always mutually consistent.
- **Reset (asynchronous assert, synchronous release):**
  - y_out=0, ch_out=0, valid_out=0, wrap_out=0, err_out=0.
  - State = IDLE, dwell counter = 0.
- Reset asserted mid-scan clears the outputs immediately. After release the scan restarts from channel 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- wrap_out and err_out are single-cycle pulses. They never assert while valid_out=0.

## Structure
- **Shared package `mux_pkg`:** state enum (IDLE, MANUAL, SCAN) and the mode encoding constants (MODE_MANUAL=0, MODE_SCAN=1).
- **One sub-module, `dwell_counter`:**
  - Parameter DWELL; inputs clk_in, rst_n_in, clr_in, en_in; output tick_out, high on the DWELL-th enabled cycle.
  - The top level uses tick_out to advance the channel.
- The slice select is written with an indexed part-select on data_in, with no per-channel generate logic.

## Test plan
All scenarios use WIDTH=8 and CHANNELS=4 unless stated.

- **Reset:** assert rst_n_in=0 mid-cycle → all outputs 0 immediately. Release with en_in=0 → valid_out stays 0.
- **Manual select:** data_in={8'hD4,8'hC3,8'hB2,8'hA1}, mode_in=0, en_in=1, sel_in=0,1,2,3 → next cycle y_out=A1,B2,C3,D4 with ch_out=0..3, valid_out=1.
- **Scan with DWELL=2:** same data, mode_in=1 → ch_out sequence 0,0,1,1,2,2,3,3,0. wrap_out pulses exactly once, on the edge where ch_out becomes 0.
- **Illegal select:** CHANNELS=3, manual with sel_in=1 then sel_in=3 → ch_out stays 1, err_out pulses for one cycle, y_out tracks channel 1.
- **Mode switch:** scanning at ch_out=2, set mode_in=0 with sel_in=0 → next cycle ch_out=0. Switch back to scan → ch_out=0 held for DWELL cycles, then 1.
- **Enable gating:** drop en_in for 3 cycles mid-scan → y_out/ch_out hold and valid_out=0. On re-enable, dwell restarts at 0 on the held channel.
